// File: rtl/eth_mdio_pkg.sv
// Shared MDIO definitions: opcodes, register addresses, sequencer states and frame builder.
// Used by the sequencer and by packetlogger's JTAG host path.
package eth_mdio_pkg;

  localparam int unsigned MDIO_FRAME_W = 32;
  localparam int unsigned MDIO_DATA_W  = 16;
  localparam int unsigned MDIO_ADDR_W  = 5;

  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam logic [MDIO_ADDR_W-1:0] MDIO_REG_BMCR = 5'd0;
  localparam logic [MDIO_ADDR_W-1:0] MDIO_REG_BMSR = 5'd1;
  localparam logic [MDIO_ADDR_W-1:0] MDIO_REG_ANAR = 5'd4;

  typedef enum logic [3:0] {
    SEQ_BOOT,
    SEQ_INIT_RD,
    SEQ_INIT_CHK,
    SEQ_INIT_AN,
    SEQ_INIT_FIN,
    SEQ_IDLE,
    SEQ_START,
    SEQ_ARM,
    SEQ_WAIT,
    SEQ_HOST_DONE,
    SEQ_POLL_DONE
  } seq_state_e;

  // Clause-22 frame {ST, OP, PHYAD, REGAD, TA, DATA}; reads carry zero TA/DATA
  function automatic logic [MDIO_FRAME_W-1:0] mdio_frame(
    input logic [1:0]             op,
    input logic [MDIO_ADDR_W-1:0] phy,
    input logic [MDIO_ADDR_W-1:0] regad,
    input logic [MDIO_DATA_W-1:0] data
  );
    logic [1:0]             ta;
    logic [MDIO_DATA_W-1:0] d;
    ta = (op == MDIO_OP_WR) ? 2'b10 : 2'b00;
    d  = (op == MDIO_OP_WR) ? data : '0;
    return {2'b01, op, phy, regad, ta, d};
  endfunction

endpackage

// File: rtl/eth_mdio_sequencer_if.sv
// Management-interface bus between the sequencer (master) and the eth_mdio engine (slave).
interface eth_mdio_sequencer_if;
  import eth_mdio_pkg::*;

  logic                    mi_read;
  logic                    mi_write;
  logic [MDIO_FRAME_W-1:0] mi_txdata;
  logic [MDIO_DATA_W-1:0]  mi_rxdata;
  logic                    mi_busy;

  modport master (
    output mi_read, mi_write, mi_txdata,
    input  mi_rxdata, mi_busy
  );

  modport slave (
    input  mi_read, mi_write, mi_txdata,
    output mi_rxdata, mi_busy
  );
endinterface

// File: rtl/eth_mdio_sequencer.sv
// Shares one eth_mdio engine between PHY bring-up, a periodic BMSR link poll and a host requester.
// Host requests win over the poll in IDLE; one transfer is outstanding at a time.
module eth_mdio_sequencer
  import eth_mdio_pkg::*;
#(
  parameter logic [MDIO_ADDR_W-1:0] PHY_ADDR     = 5'd1,
  parameter logic [MDIO_DATA_W-1:0] ANAR_VALUE   = 16'h01E1,
  parameter logic [23:0]            POLL_CYCLES  = 24'd5_000_000,
  parameter logic [7:0]             RST_POLL_MAX = 8'd100
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    host_req,
  input  logic [MDIO_FRAME_W-1:0] host_txdata,
  output logic                    host_ack,
  output logic [MDIO_DATA_W-1:0]  host_rdata,
  eth_mdio_sequencer_if.master    mi,
  output logic                    init_done,
  output logic                    init_error,
  output logic                    link_up
);

  localparam logic [MDIO_DATA_W-1:0] BMCR_RESET  = 16'h8000;
  localparam logic [MDIO_DATA_W-1:0] BMCR_AN_RST = 16'h1200;

  seq_state_e              state_q, state_d;
  seq_state_e              ret_q, ret_d;
  logic [MDIO_DATA_W-1:0]  rx_q, rx_d;
  logic [7:0]              rd_cnt_q, rd_cnt_d;
  logic [MDIO_FRAME_W-1:0] txdata_q, txdata_d;
  logic                    mi_write_q, mi_write_d;
  logic                    mi_read_q, mi_read_d;
  logic                    host_ack_q, host_ack_d;
  logic [MDIO_DATA_W-1:0]  host_rdata_q, host_rdata_d;
  logic                    init_done_q, init_done_d;
  logic                    init_error_q, init_error_d;
  logic                    link_up_q, link_up_d;
  logic                    poll_take_c;
  logic [23:0]             poll_tmr_q;
  logic                    poll_pend_q;

  // Free-running poll timer; a new expiry outranks the clear from a poll starting the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      poll_tmr_q  <= POLL_CYCLES - 24'd1;
      poll_pend_q <= 1'b0;
    end else begin
      if (poll_tmr_q == 24'd0) begin
        poll_tmr_q  <= POLL_CYCLES - 24'd1;
        poll_pend_q <= 1'b1;
      end else begin
        poll_tmr_q <= poll_tmr_q - 24'd1;
        if (poll_take_c) poll_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= SEQ_BOOT;
      ret_q        <= SEQ_IDLE;
      rx_q         <= '0;
      rd_cnt_q     <= '0;
      txdata_q     <= '0;
      mi_write_q   <= 1'b0;
      mi_read_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      rx_q         <= rx_d;
      rd_cnt_q     <= rd_cnt_d;
      txdata_q     <= txdata_d;
      mi_write_q   <= mi_write_d;
      mi_read_q    <= mi_read_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      link_up_q    <= link_up_d;
    end
  end

  // Callers load txdata/ret and jump to START; WAIT returns to ret with rx_q captured
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    rx_d         = rx_q;
    rd_cnt_d     = rd_cnt_q;
    txdata_d     = txdata_q;
    mi_write_d   = 1'b0;
    mi_read_d    = 1'b0;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    link_up_d    = link_up_q;
    poll_take_c  = 1'b0;

    case (state_q)
      SEQ_BOOT: begin
        if (!mi.mi_busy) begin
          txdata_d = mdio_frame(MDIO_OP_WR, PHY_ADDR, MDIO_REG_BMCR, BMCR_RESET);
          ret_d    = SEQ_INIT_RD;
          rd_cnt_d = '0;
          state_d  = SEQ_START;
        end
      end
      SEQ_INIT_RD: begin
        txdata_d = mdio_frame(MDIO_OP_RD, PHY_ADDR, MDIO_REG_BMCR, '0);
        ret_d    = SEQ_INIT_CHK;
        rd_cnt_d = rd_cnt_q + 8'd1;
        state_d  = SEQ_START;
      end
      SEQ_INIT_CHK: begin
        if (!rx_q[15]) begin
          txdata_d = mdio_frame(MDIO_OP_WR, PHY_ADDR, MDIO_REG_ANAR, ANAR_VALUE);
          ret_d    = SEQ_INIT_AN;
          state_d  = SEQ_START;
        end else if (rd_cnt_q >= RST_POLL_MAX) begin
          init_error_d = 1'b1;
          init_done_d  = 1'b1;
          state_d      = SEQ_IDLE;
        end else begin
          state_d = SEQ_INIT_RD;
        end
      end
      SEQ_INIT_AN: begin
        txdata_d = mdio_frame(MDIO_OP_WR, PHY_ADDR, MDIO_REG_BMCR, BMCR_AN_RST);
        ret_d    = SEQ_INIT_FIN;
        state_d  = SEQ_START;
      end
      SEQ_INIT_FIN: begin
        init_done_d = 1'b1;
        state_d     = SEQ_IDLE;
      end
      SEQ_IDLE: begin
        // host_ack is high for the first IDLE cycle after a host transfer: skip a still-held req
        if (host_req && !host_ack_q) begin
          txdata_d = host_txdata;
          ret_d    = SEQ_HOST_DONE;
          state_d  = SEQ_START;
        end else if (poll_pend_q) begin
          txdata_d    = mdio_frame(MDIO_OP_RD, PHY_ADDR, MDIO_REG_BMSR, '0);
          ret_d       = SEQ_POLL_DONE;
          poll_take_c = 1'b1;
          state_d     = SEQ_START;
        end
      end
      SEQ_START: begin
        mi_write_d = 1'b1;
        mi_read_d  = (txdata_q[29:28] == MDIO_OP_RD);
        state_d    = SEQ_ARM;
      end
      SEQ_ARM: begin
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (!mi.mi_busy) begin
          rx_d    = mi.mi_rxdata;
          state_d = ret_q;
        end
      end
      SEQ_HOST_DONE: begin
        host_ack_d   = 1'b1;
        host_rdata_d = rx_q;
        state_d      = SEQ_IDLE;
      end
      SEQ_POLL_DONE: begin
        link_up_d = rx_q[2];
        state_d   = SEQ_IDLE;
      end
      default: state_d = SEQ_BOOT;
    endcase
  end

  assign mi.mi_write  = mi_write_q;
  assign mi.mi_read   = mi_read_q;
  assign mi.mi_txdata = txdata_q;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign init_done    = init_done_q;
  assign init_error   = init_error_q;
  assign link_up      = link_up_q;

endmodule
